// File: rtl/cineraria_alarmsched_pkg.sv
// Shared constants for the alarm scheduler: register map, CTRL bit positions and scan states.
package cineraria_alarmsched_pkg;

  localparam logic [4:0] ADDR_STATUS  = 5'd0;
  localparam logic [4:0] ADDR_IRQMASK = 5'd1;
  localparam logic [4:0] ADDR_GCTRL   = 5'd2;
  localparam logic [4:0] ADDR_CH_BASE = 5'd8;
  localparam int         CH_STRIDE    = 4;

  localparam logic [1:0] OFS_RELOAD = 2'd0;
  localparam logic [1:0] OFS_COUNT  = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int STATUS_OVERRUN = 15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/cineraria_alarmsched_svc.sv
// Shared decrement/compare unit: computes one channel's next COUNT, run bit and expiry.
module cineraria_alarmsched_svc
  import cineraria_alarmsched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] reload,
  input  logic             periodic,
  output logic [CNT_W-1:0] next_count,
  output logic             expire,
  output logic             next_run
);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    next_count = count - CNT_W'(1);
    expire     = 1'b0;
    next_run   = 1'b1;
    if (count <= CNT_W'(1)) begin
      expire = 1'b1;
      if (periodic) begin
        // A stored RELOAD of zero behaves as one so a periodic channel never stalls at zero.
        next_count = (reload == '0) ? CNT_W'(1) : reload;
      end else begin
        next_count = '0;
        next_run   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cineraria_core_alarmsched.sv
// Alarm scheduler: up to six countdown channels serviced one per cycle after each timer tick.
// Optional CINERARIA_ALARMSCHED_OVERRUN_EN adds a one-deep tick queue and a sticky overrun flag.
module cineraria_core_alarmsched
  import cineraria_alarmsched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [4:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  logic [NUM_CH-1:0] expired_q;
  logic [NUM_CH-1:0] irqmask_q;
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] periodic_q;
  logic              gen_q;
  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  scan_state_t       state_q;
  logic [2:0]        idx_q;
  logic              overrun_q;
  logic              restart;

  logic              wr, wr_status, wr_irqmask, wr_gctrl, ch_hit;
  logic [4:0]        ch_off;
  logic [2:0]        ch_sel;
  logic [NUM_CH-1:0] wr_reload, wr_ctrl;
  logic [CNT_W-1:0]  eff_reload [NUM_CH];

  always_comb begin
    wr         = chipselect && !write_n;
    wr_status  = wr && (address == ADDR_STATUS);
    wr_irqmask = wr && (address == ADDR_IRQMASK);
    wr_gctrl   = wr && (address == ADDR_GCTRL);
    ch_off     = address - ADDR_CH_BASE;
    ch_sel     = 3'(ch_off >> $clog2(CH_STRIDE));
    ch_hit     = (address >= ADDR_CH_BASE) && (ch_sel < 3'(NUM_CH));
    for (int c = 0; c < NUM_CH; c++) begin
      wr_reload[c]  = wr && ch_hit && (ch_sel == 3'(c)) && (address[1:0] == OFS_RELOAD);
      wr_ctrl[c]    = wr && ch_hit && (ch_sel == 3'(c)) && (address[1:0] == OFS_CTRL);
      eff_reload[c] = (reload_q[c] == '0) ? CNT_W'(1) : reload_q[c];
    end
  end

  // Operands of the channel under service, selected by the scan index.
  logic              scanning, last_idx;
  logic [CNT_W-1:0]  svc_count, svc_reload, svc_next_count;
  logic              svc_periodic, svc_expire, svc_next_run;
  logic [NUM_CH-1:0] svc_hit, expire_set;

  always_comb begin
    svc_count    = '0;
    svc_reload   = '0;
    svc_periodic = 1'b0;
    scanning     = (state_q == ST_SCAN);
    last_idx     = (idx_q == 3'(NUM_CH - 1));
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx_q == 3'(c)) begin
        svc_count    = count_q[c];
        svc_reload   = reload_q[c];
        svc_periodic = periodic_q[c];
      end
      // A CPU write to this channel's RELOAD or CTRL in its service cycle takes precedence.
      svc_hit[c] = scanning && (idx_q == 3'(c)) && run_q[c] && !wr_reload[c] && !wr_ctrl[c];
    end
    expire_set = svc_hit & {NUM_CH{svc_expire}};
  end

  cineraria_alarmsched_svc #(
    .CNT_W (CNT_W)
  ) u_svc (
    .count      (svc_count),
    .reload     (svc_reload),
    .periodic   (svc_periodic),
    .next_count (svc_next_count),
    .expire     (svc_expire),
    .next_run   (svc_next_run)
  );

`ifdef CINERARIA_ALARMSCHED_OVERRUN_EN
  logic gen_eff, scan_tick, pending_q, pending_d, overrun_set;

  always_comb begin
    // Disabling mid-scan takes effect this cycle so the pending tick is discarded.
    gen_eff     = wr_gctrl ? writedata[0] : gen_q;
    scan_tick   = tick && scanning && gen_eff;
    overrun_set = scan_tick && pending_q;
    pending_d   = pending_q || scan_tick;
    restart     = 1'b0;
    if (scanning && last_idx) begin
      restart   = pending_d;
      pending_d = 1'b0;
    end
    if (!gen_eff) begin
      restart   = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_set | (overrun_q & ~(wr_status & writedata[STATUS_OVERRUN]));
    end
  end
`else
  assign restart   = 1'b0;
  assign overrun_q = 1'b0;
`endif

  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (address[1:0])
            OFS_RELOAD: rd_mux = 16'(reload_q[c]);
            OFS_COUNT:  rd_mux = 16'(count_q[c]);
            OFS_CTRL: begin
              rd_mux[CTRL_RUN]      = run_q[c];
              rd_mux[CTRL_PERIODIC] = periodic_q[c];
            end
            OFS_RSVD:   rd_mux = '0;
            default:    rd_mux = '0;
          endcase
        end
      end
    end else begin
      case (address)
        ADDR_STATUS: begin
          rd_mux[NUM_CH-1:0]     = expired_q;
          rd_mux[STATUS_OVERRUN] = overrun_q;
        end
        ADDR_IRQMASK: rd_mux[NUM_CH-1:0] = irqmask_q;
        ADDR_GCTRL:   rd_mux[0] = gen_q;
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expired_q  <= '0;
      irqmask_q  <= '0;
      run_q      <= '0;
      periodic_q <= '0;
      gen_q      <= 1'b0;
      // NOTE: the channel arrays are architectural registers that must read 0 after reset, so they are reset too.
      for (int c = 0; c < NUM_CH; c++) begin
        reload_q[c] <= '0;
        count_q[c]  <= '0;
      end
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      // An expiry landing in the same cycle as its W1C survives the clear.
      expired_q <= (expired_q & ~(wr_status ? writedata[NUM_CH-1:0] : '0)) | expire_set;
      if (wr_irqmask) irqmask_q <= writedata[NUM_CH-1:0];
      if (wr_gctrl)   gen_q     <= writedata[0];

      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_reload[c]) reload_q[c] <= writedata[CNT_W-1:0];
        if (wr_ctrl[c]) begin
          run_q[c]      <= writedata[CTRL_RUN];
          periodic_q[c] <= writedata[CTRL_PERIODIC];
          if (writedata[CTRL_RUN] && !run_q[c]) count_q[c] <= eff_reload[c];
        end else if (svc_hit[c]) begin
          count_q[c] <= svc_next_count;
          run_q[c]   <= svc_next_run;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (tick && gen_q) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
          end
        end
        ST_SCAN: begin
          if (last_idx) begin
            if (!restart) state_q <= ST_IDLE;
            idx_q <= '0;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq = |(expired_q & irqmask_q);

  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_cineraria_core_alarmsched.sv
// Directed bench for cineraria_core_alarmsched (NUM_CH=4, CNT_W=16); expected values are hand-derived.
module tb_cineraria_core_alarmsched;

  logic        clk = 1'b0;
  logic        reset, tick, chipselect, write_n;
  logic [4:0]  address;
  logic [15:0] writedata, readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] A_STATUS = 5'd0;
  localparam logic [4:0] A_MASK   = 5'd1;
  localparam logic [4:0] A_GCTRL  = 5'd2;

`ifdef CINERARIA_ALARMSCHED_OVERRUN_EN
  localparam logic [15:0] EXP_OVR_COUNT  = 16'd8;
  localparam logic [15:0] EXP_OVR_STATUS = 16'h8000;
`else
  localparam logic [15:0] EXP_OVR_COUNT  = 16'd9;
  localparam logic [15:0] EXP_OVR_STATUS = 16'h0000;
`endif

  logic [15:0] exp_p [1:7] = '{16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3, 16'd2};

  always #5 clk = ~clk;

  cineraria_core_alarmsched #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ra(input int c, input int ofs);
    return 5'(8 + 4 * c + ofs);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [15:0] exp);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(tag, readdata, exp);
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    idle(3);
    reset = 1'b0;
    check("rst_readdata", readdata, 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    rd_check("rst_status", A_STATUS, 16'h0);
    rd_check("rst_ch0_count", ra(0, 1), 16'h0);

    // Periodic channel 0, RELOAD=3
    cpu_write(A_GCTRL, 16'h1);
    cpu_write(ra(0, 0), 16'd3);
    cpu_write(ra(0, 2), 16'h3);
    rd_check("p_count_arm", ra(0, 1), 16'd3);
    for (int k = 1; k <= 7; k++) begin
      pulse_tick();
      idle(8);
      rd_check($sformatf("p_count_t%0d", k), ra(0, 1), exp_p[k]);
      rd_check($sformatf("p_status_t%0d", k), A_STATUS, (k % 3 == 0) ? 16'h1 : 16'h0);
      if (k % 3 == 0) begin
        check($sformatf("p_irq_masked_t%0d", k), 16'(irq), 16'h0);
        if (k == 6) begin
          cpu_write(A_MASK, 16'h1);
          check("p_irq_unmasked", 16'(irq), 16'h1);
        end
        cpu_write(A_STATUS, 16'h1);
        check($sformatf("p_irq_clr_t%0d", k), 16'(irq), 16'h0);
      end
    end
    cpu_write(A_MASK, 16'h0);
    cpu_write(ra(0, 2), 16'h0);

    // One-shot channel 2, RELOAD=2
    cpu_write(A_MASK, 16'h4);
    cpu_write(ra(2, 0), 16'd2);
    cpu_write(ra(2, 2), 16'h1);
    pulse_tick(); idle(8);
    rd_check("os_count_t1", ra(2, 1), 16'd1);
    rd_check("os_status_t1", A_STATUS, 16'h0);
    pulse_tick(); idle(8);
    rd_check("os_count_t2", ra(2, 1), 16'd0);
    rd_check("os_status_t2", A_STATUS, 16'h4);
    rd_check("os_ctrl_t2", ra(2, 2), 16'h0);
    check("os_irq_set", 16'(irq), 16'h1);
    pulse_tick(); idle(8);
    rd_check("os_count_t3", ra(2, 1), 16'd0);
    rd_check("os_status_t3", A_STATUS, 16'h4);
    cpu_write(A_STATUS, 16'h4);
    check("os_irq_fall", 16'(irq), 16'h0);
    rd_check("os_status_clr", A_STATUS, 16'h0);

    // Scan latency: channel i visible exactly at T+2+i
    for (int c = 0; c < 4; c++) begin
      cpu_write(ra(c, 0), 16'd1);
      cpu_write(ra(c, 2), 16'h3);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_write(A_MASK, 16'(1 << i));
      cpu_write(A_STATUS, 16'hF);
      pulse_tick();
      idle(i);
      check($sformatf("lat_ch%0d_early", i), 16'(irq), 16'h0);
      idle(1);
      check($sformatf("lat_ch%0d_on_time", i), 16'(irq), 16'h1);
      idle(6);
    end
    for (int c = 0; c < 4; c++) cpu_write(ra(c, 2), 16'h0);
    cpu_write(A_STATUS, 16'hF);
    cpu_write(A_MASK, 16'h0);

    // Collisions on channel 1: the CPU write in its service cycle wins
    cpu_write(ra(1, 0), 16'd5);
    cpu_write(ra(1, 2), 16'h3);
    rd_check("col_arm", ra(1, 1), 16'd5);
    pulse_tick(); cpu_write(ra(1, 2), 16'h3); idle(6);
    rd_check("col_ctrl_skip", ra(1, 1), 16'd5);
    pulse_tick(); idle(6);
    rd_check("col_dec", ra(1, 1), 16'd4);
    pulse_tick(); cpu_write(ra(1, 0), 16'd7); idle(6);
    rd_check("col_reload_skip", ra(1, 1), 16'd4);
    rd_check("col_reload_val", ra(1, 0), 16'd7);
    cpu_write(ra(1, 2), 16'h0);
    pulse_tick(); cpu_write(ra(1, 2), 16'h3); idle(6);
    rd_check("col_ctrl_rearm", ra(1, 1), 16'd7);
    cpu_write(ra(1, 2), 16'h0);

    // Expiry of channel 3 and its W1C in the same cycle: the set wins
    cpu_write(ra(3, 0), 16'd1);
    cpu_write(ra(3, 2), 16'h3);
    cpu_write(A_STATUS, 16'hF);
    pulse_tick(); idle(2); cpu_write(A_STATUS, 16'h8); idle(4);
    rd_check("w1c_set_wins", A_STATUS, 16'h8);
    cpu_write(A_STATUS, 16'h8);
    rd_check("w1c_clear", A_STATUS, 16'h0);
    cpu_write(ra(3, 2), 16'h0);

    // Ticks on three consecutive cycles
    cpu_write(ra(0, 0), 16'd10);
    cpu_write(ra(0, 2), 16'h3);
    cpu_write(A_MASK, 16'hF);
    @(negedge clk); tick = 1'b1;
    idle(3); tick = 1'b0;
    idle(12);
    rd_check("ovr_count", ra(0, 1), EXP_OVR_COUNT);
    rd_check("ovr_status", A_STATUS, EXP_OVR_STATUS);
    check("ovr_no_irq", 16'(irq), 16'h0);
    rd_check("rsvd_read", ra(0, 3), 16'h0);
    rd_check("absent_ch4", ra(4, 1), 16'h0);
    cpu_write(A_STATUS, 16'h8000);
    rd_check("ovr_clear", A_STATUS, 16'h0);

    // RELOAD of zero behaves as one
    cpu_write(ra(2, 0), 16'd0);
    cpu_write(ra(2, 2), 16'h1);
    rd_check("zr_count", ra(2, 1), 16'd1);
    pulse_tick(); idle(6);
    rd_check("zr_status", A_STATUS, 16'h4);
    check("zr_irq", 16'(irq), 16'h1);

    // Reset in the middle of a scan
    pulse_tick();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_irq", 16'(irq), 16'h0);
    check("mid_rst_readdata", readdata, 16'h0);
    rd_check("mid_rst_gctrl", A_GCTRL, 16'h0);
    rd_check("mid_rst_mask", A_MASK, 16'h0);
    rd_check("mid_rst_status", A_STATUS, 16'h0);
    rd_check("mid_rst_ch0_count", ra(0, 1), 16'h0);
    rd_check("mid_rst_ch0_ctrl", ra(0, 2), 16'h0);
    cpu_write(ra(0, 0), 16'd2);
    cpu_write(ra(0, 2), 16'h1);
    pulse_tick(); idle(6);
    rd_check("dis_tick_count", ra(0, 1), 16'd2);
    rd_check("dis_tick_status", A_STATUS, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
